mdu: RTL

Multiply/divide unit sitting directly downstream of the general-purpose register file in the datapath. It consumes the two register read operands (RData1 as A, RData2 as B) and performs MIPS mult/multu/div/divu over a fixed multi-cycle latency, holding results in internal HI/LO registers. It also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo. Busy is the signal the controller uses to stall any instruction that touches HI/LO.

---
 rtl/mdu.sv | 119 +++++++++++
 1 files changed

// File: rtl/mdu.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers and mthi/mtlo write ports.
// The result is computed at acceptance and held back until the fixed latency expires.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiWrite,
  input  logic        LoWrite,
  output logic        Busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] dvd, dvs, uq, ur, quot, rem;
  logic [31:0] res_hi, res_lo;

  // Operands are sign- or zero-extended to 64 bits so one unsigned multiply serves both.
  always_comb begin
    a_ext = Op[0] ? {32'b0, A} : {{32{A[31]}}, A};
    b_ext = Op[0] ? {32'b0, B} : {{32{B[31]}}, B};
    prod  = a_ext * b_ext;
  end

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000 r 0.
  always_comb begin
    a_neg = ~Op[0] & A[31];
    b_neg = ~Op[0] & B[31];
    dvd   = a_neg ? (32'd0 - A) : A;
    dvs   = (B == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - B) : B);
    uq    = dvd / dvs;
    ur    = dvd % dvs;
    quot  = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem   = a_neg ? (32'd0 - ur) : ur;
  end

  always_comb begin
    if (!Op[1]) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (B == 32'd0) begin
      res_hi = A;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          cnt_d     = Op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
          state_d   = StRun;
        end else begin
          if (HiWrite) hi_d = A;
          if (LoWrite) lo_d = A;
        end
      end
      StRun: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy = (state_q == StRun);
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule
